// File: rtl/flex_counter_pkg.sv
// Shared constants and types for the multi-channel flexible counter.
package flex_counter_pkg;

    // Direction encoding on count_down.
    localparam logic CNT_UP   = 1'b0;
    localparam logic CNT_DOWN = 1'b1;

    localparam int unsigned DEFAULT_CNT_BITS = 4;
    localparam int unsigned DEFAULT_NUM_CH   = 2;

    // Per-cycle channel action after priority resolution.
    typedef enum logic [1:0] {
        ActHold,
        ActCount,
        ActLoad,
        ActClear
    } ch_act_e;

    // Priority: clear > load > count > hold.
    function automatic ch_act_e decode_act(input logic clear, input logic load, input logic en);
        ch_act_e act;
        act = ActHold;
        if (clear) begin
            act = ActClear;
        end else if (load) begin
            act = ActLoad;
        end else if (en) begin
            act = ActCount;
        end
        return act;
    endfunction

endpackage

// File: rtl/flex_counter_ch.sv
// One counter channel: count register, terminal flag, wrap pulse and the
// combinational wrap event used by the next channel when cascaded.
module flex_counter_ch
    import flex_counter_pkg::*;
#(
    parameter int unsigned NUM_CNT_BITS = DEFAULT_CNT_BITS,
    parameter bit          STICKY       = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    en_i,
    input  logic                    count_down_i,
    input  logic                    clear_i,
    input  logic                    load_i,
    input  logic [NUM_CNT_BITS-1:0] load_val_i,
    input  logic [NUM_CNT_BITS-1:0] rollover_val_i,
    output logic [NUM_CNT_BITS-1:0] count_o,
    output logic                    rollover_flag_o,
    output logic                    wrap_pulse_o,
    output logic                    wrap_evt_o
);

    typedef logic [NUM_CNT_BITS-1:0] cnt_t;

    cnt_t    cnt_q, cnt_d;
    cnt_t    terminal;
    cnt_t    cnt_step;
    logic    flag_q, flag_d;
    logic    pulse_q, pulse_d;
    logic    next_hit;
    ch_act_e act;

    // Action decode, terminal selection and the stepped count value.
    always_comb begin
        act      = decode_act(clear_i, load_i, en_i);
        terminal = (count_down_i == CNT_DOWN) ? cnt_t'(0) : rollover_val_i;
        if (count_down_i == CNT_DOWN) begin
            cnt_step = (cnt_q == cnt_t'(0)) ? rollover_val_i : cnt_q - cnt_t'(1);
        end else begin
            // A count above the terminal (after load or a lowered terminal) wraps to 0.
            cnt_step = (cnt_q >= rollover_val_i) ? cnt_t'(0) : cnt_q + cnt_t'(1);
        end
        wrap_evt_o = (act == ActCount) && (cnt_q == terminal);
    end

    // Next-state for count, flag and pulse.
    always_comb begin
        cnt_d    = cnt_q;
        pulse_d  = 1'b0;
        flag_d   = flag_q;
        next_hit = 1'b0;
        unique case (act)
            ActClear: cnt_d = cnt_t'(0);
            ActLoad:  cnt_d = load_val_i;
            ActCount: begin
                cnt_d   = cnt_step;
                pulse_d = wrap_evt_o;
            end
            ActHold:  cnt_d = cnt_q;
        endcase
        if (act == ActClear) begin
            flag_d = 1'b0;
        end else begin
            next_hit = (cnt_d == terminal);
            flag_d   = STICKY ? (flag_q | next_hit) : next_hit;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q   <= cnt_t'(0);
            flag_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            pulse_q <= pulse_d;
        end
    end

    assign count_o         = cnt_q;
    assign rollover_flag_o = flag_q;
    assign wrap_pulse_o    = pulse_q;

endmodule

// File: rtl/flex_counter_mc.sv
// Multi-channel flexible counter: NUM_CH independent channels, optionally
// cascaded so each channel only advances on its predecessor's wrap.
module flex_counter_mc
    import flex_counter_pkg::*;
#(
    parameter int unsigned NUM_CNT_BITS = DEFAULT_CNT_BITS,
    parameter int unsigned NUM_CH       = DEFAULT_NUM_CH,
    parameter bit          CASCADE      = 1'b0,
    parameter bit          STICKY       = 1'b0
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic [NUM_CH-1:0]              count_enable,
    input  logic [NUM_CH-1:0]              count_down,
    input  logic [NUM_CH-1:0]              clear,
    input  logic [NUM_CH-1:0]              load,
    input  logic [NUM_CH*NUM_CNT_BITS-1:0] load_val,
    input  logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CH*NUM_CNT_BITS-1:0] count_out,
    output logic [NUM_CH-1:0]              rollover_flag,
    output logic [NUM_CH-1:0]              wrap_pulse
);

    logic [NUM_CH-1:0] wrap_evt;
    logic [NUM_CH-1:0] en;
    logic              unused_wrap_evt;

    // The last channel's wrap event (and all of them without cascade) feed nothing.
    assign unused_wrap_evt = ^wrap_evt;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        if (CASCADE && (i > 0)) begin : g_cascade
            assign en[i] = count_enable[i] & wrap_evt[i-1];
        end else begin : g_direct
            assign en[i] = count_enable[i];
        end

        flex_counter_ch #(
            .NUM_CNT_BITS (NUM_CNT_BITS),
            .STICKY       (STICKY)
        ) u_ch (
            .clk_i           (clk),
            .rst_ni          (n_rst),
            .en_i            (en[i]),
            .count_down_i    (count_down[i]),
            .clear_i         (clear[i]),
            .load_i          (load[i]),
            .load_val_i      (load_val[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
            .rollover_val_i  (rollover_val[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
            .count_o         (count_out[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
            .rollover_flag_o (rollover_flag[i]),
            .wrap_pulse_o    (wrap_pulse[i]),
            .wrap_evt_o      (wrap_evt[i])
        );
    end

endmodule

// File: tb/tb_flex_counter_mc.sv
// Bench for flex_counter_mc: a plain instance and a cascaded+sticky instance
// share stimulus; a behavioural model feeds a scoreboard checked every cycle.
module tb_flex_counter_mc;

    logic       clk;
    logic       n_rst;
    logic [1:0] ce, cd, clr, ld;
    logic [7:0] lv, rv;

    logic [7:0] cnt_a, cnt_b;
    logic [1:0] flag_a, flag_b, pulse_a, pulse_b;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] cnt_a;
        logic [1:0] flag_a;
        logic [1:0] pulse_a;
        logic [7:0] cnt_b;
        logic [1:0] flag_b;
        logic [1:0] pulse_b;
    } exp_t;

    exp_t sb[$];

    // Model state indexed [instance][channel]; instance 1 is cascade+sticky.
    logic [3:0] m_cnt   [2][2];
    logic       m_flag  [2][2];
    logic       m_pulse [2][2];

    flex_counter_mc #(
        .NUM_CNT_BITS (4),
        .NUM_CH       (2),
        .CASCADE      (1'b0),
        .STICKY       (1'b0)
    ) dut_a (
        .clk           (clk),
        .n_rst         (n_rst),
        .count_enable  (ce),
        .count_down    (cd),
        .clear         (clr),
        .load          (ld),
        .load_val      (lv),
        .rollover_val  (rv),
        .count_out     (cnt_a),
        .rollover_flag (flag_a),
        .wrap_pulse    (pulse_a)
    );

    flex_counter_mc #(
        .NUM_CNT_BITS (4),
        .NUM_CH       (2),
        .CASCADE      (1'b1),
        .STICKY       (1'b1)
    ) dut_b (
        .clk           (clk),
        .n_rst         (n_rst),
        .count_enable  (ce),
        .count_down    (cd),
        .clear         (clr),
        .load          (ld),
        .load_val      (lv),
        .rollover_val  (rv),
        .count_out     (cnt_b),
        .rollover_flag (flag_b),
        .wrap_pulse    (pulse_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model by one edge using the inputs currently driven; push expectation.
    task automatic model_step();
        exp_t e;
        for (int inst = 0; inst < 2; inst++) begin
            logic prev_evt;
            prev_evt = 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                logic [3:0] c, r, l, term, nxt;
                logic       en, evt, hit;
                c    = m_cnt[inst][ch];
                r    = rv[ch*4 +: 4];
                l    = lv[ch*4 +: 4];
                term = cd[ch] ? 4'd0 : r;
                en   = ce[ch] && ((inst == 0) || (ch == 0) || prev_evt);
                evt  = en && !clr[ch] && !ld[ch] && (c == term);
                if (!n_rst || clr[ch]) begin
                    m_cnt[inst][ch]   = 4'd0;
                    m_flag[inst][ch]  = 1'b0;
                    m_pulse[inst][ch] = 1'b0;
                end else begin
                    if (ld[ch]) nxt = l;
                    else if (en && cd[ch]) nxt = (c == 4'd0) ? r : c - 4'd1;
                    else if (en) nxt = (c >= r) ? 4'd0 : c + 4'd1;
                    else nxt = c;
                    hit = (nxt == term);
                    m_flag[inst][ch]  = (inst == 1) ? (m_flag[inst][ch] | hit) : hit;
                    m_pulse[inst][ch] = evt;
                    m_cnt[inst][ch]   = nxt;
                end
                prev_evt = evt;
            end
        end
        for (int ch = 0; ch < 2; ch++) begin
            e.cnt_a[ch*4 +: 4] = m_cnt[0][ch];
            e.flag_a[ch]       = m_flag[0][ch];
            e.pulse_a[ch]      = m_pulse[0][ch];
            e.cnt_b[ch*4 +: 4] = m_cnt[1][ch];
            e.flag_b[ch]       = m_flag[1][ch];
            e.pulse_b[ch]      = m_pulse[1][ch];
        end
        sb.push_back(e);
    endtask

    // One clock: predict, take the edge, sample 1 time unit later and score.
    task automatic cycle();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks += 6;
        if (cnt_a !== e.cnt_a) begin
            errors++;
            $display("FAIL sb_cnt_a t=%0t got %h exp %h", $time, cnt_a, e.cnt_a);
        end
        if (flag_a !== e.flag_a) begin
            errors++;
            $display("FAIL sb_flag_a t=%0t got %b exp %b", $time, flag_a, e.flag_a);
        end
        if (pulse_a !== e.pulse_a) begin
            errors++;
            $display("FAIL sb_pulse_a t=%0t got %b exp %b", $time, pulse_a, e.pulse_a);
        end
        if (cnt_b !== e.cnt_b) begin
            errors++;
            $display("FAIL sb_cnt_b t=%0t got %h exp %h", $time, cnt_b, e.cnt_b);
        end
        if (flag_b !== e.flag_b) begin
            errors++;
            $display("FAIL sb_flag_b t=%0t got %b exp %b", $time, flag_b, e.flag_b);
        end
        if (pulse_b !== e.pulse_b) begin
            errors++;
            $display("FAIL sb_pulse_b t=%0t got %b exp %b", $time, pulse_b, e.pulse_b);
        end
    endtask

    task automatic clear_all();
        clr = 2'b11;
        ld  = 2'b00;
        cycle();
        clr = 2'b00;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        ce = 2'b11; cd = 2'b00; clr = 2'b00; ld = 2'b11;
        lv = 8'hff; rv = 8'h55;
        repeat (2) cycle();
        checks++;
        if (cnt_a !== 8'h00 || cnt_b !== 8'h00 || flag_a !== 2'b00 || pulse_b !== 2'b00) begin
            errors++;
            $display("FAIL reset got cnt_a=%h cnt_b=%h flag_a=%b exp all 0", cnt_a, cnt_b, flag_a);
        end
        n_rst = 1'b1;
        ld = 2'b00; ce = 2'b00;
        cycle();
    endtask

    task automatic test_up();
        clear_all();
        rv = {4'd5, 4'd5}; cd = 2'b00; ce = 2'b11;
        for (int k = 0; k < 7; k++) begin
            logic [3:0] exp_c;
            cycle();
            exp_c = 4'((k + 1) % 6);
            checks++;
            if (cnt_a[3:0] !== exp_c || flag_a[0] !== (exp_c == 4'd5) || pulse_a[0] !== (k == 5)) begin
                errors++;
                $display("FAIL up_seq k=%0d got cnt=%0d flag=%b pulse=%b exp cnt=%0d", k,
                         cnt_a[3:0], flag_a[0], pulse_a[0], exp_c);
            end
        end
    endtask

    task automatic test_down();
        clear_all();
        rv = {4'd3, 4'd3}; cd = 2'b11; ce = 2'b11;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] exp_c;
            cycle();
            exp_c = (k == 4) ? 4'd3 : 4'(3 - k);
            checks++;
            if (cnt_a[3:0] !== exp_c || flag_a[0] !== (exp_c == 4'd0)) begin
                errors++;
                $display("FAIL down_seq k=%0d got cnt=%0d flag=%b exp cnt=%0d", k,
                         cnt_a[3:0], flag_a[0], exp_c);
            end
        end
    endtask

    task automatic test_cascade();
        cd = 2'b00;
        clear_all();
        rv = {4'd2, 4'd2}; ce = 2'b11;
        for (int k = 1; k <= 9; k++) begin
            cycle();
            checks++;
            if (cnt_b[7:4] !== 4'((k / 3) % 3) || cnt_a[7:4] !== 4'(k % 3)) begin
                errors++;
                $display("FAIL cascade k=%0d got b_ch1=%0d a_ch1=%0d exp %0d %0d", k,
                         cnt_b[7:4], cnt_a[7:4], (k / 3) % 3, k % 3);
            end
        end
    endtask

    task automatic test_sticky();
        cd = 2'b00;
        clear_all();
        rv = {4'd2, 4'd2}; ce = 2'b01;
        for (int k = 1; k <= 4; k++) begin
            cycle();
            checks++;
            if (flag_b[0] !== (k >= 2)) begin
                errors++;
                $display("FAIL sticky_hold k=%0d got %b exp %b", k, flag_b[0], k >= 2);
            end
        end
        ce = 2'b00; clr = 2'b01;
        cycle();
        checks++;
        if (flag_b[0] !== 1'b0 || cnt_b[3:0] !== 4'd0) begin
            errors++;
            $display("FAIL sticky_clear got flag=%b cnt=%0d exp 0 0", flag_b[0], cnt_b[3:0]);
        end
        ld = 2'b01; lv = 8'h07;
        cycle();
        checks++;
        if (cnt_b[3:0] !== 4'd0 || cnt_a[3:0] !== 4'd0) begin
            errors++;
            $display("FAIL clear_load got %0d/%0d exp 0", cnt_b[3:0], cnt_a[3:0]);
        end
        clr = 2'b00; ld = 2'b00;
    endtask

    task automatic test_rv_zero();
        cd = 2'b00;
        clear_all();
        rv = 8'h00; ce = 2'b11;
        repeat (3) begin
            cycle();
            checks++;
            if (cnt_a[3:0] !== 4'd0 || flag_a[0] !== 1'b1 || pulse_a[0] !== 1'b1) begin
                errors++;
                $display("FAIL rv_zero got cnt=%0d flag=%b pulse=%b exp 0 1 1",
                         cnt_a[3:0], flag_a[0], pulse_a[0]);
            end
        end
    endtask

    task automatic test_load_over();
        cd = 2'b00; ce = 2'b00;
        ld = 2'b11; lv = {4'd9, 4'd9}; rv = {4'd4, 4'd4};
        cycle();
        ld = 2'b00; ce = 2'b11;
        cycle();
        checks++;
        if (cnt_a[3:0] !== 4'd0 || pulse_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL load_over got cnt=%0d pulse=%b exp 0 0", cnt_a[3:0], pulse_a[0]);
        end
        repeat (3) cycle();
        checks++;
        if (cnt_a[3:0] !== 4'd3) begin
            errors++;
            $display("FAIL pre_reset got %0d exp 3", cnt_a[3:0]);
        end
        n_rst = 1'b0;
        cycle();
        checks++;
        if ({cnt_a, flag_a, pulse_a, cnt_b, flag_b, pulse_b} !== 24'h0) begin
            errors++;
            $display("FAIL mid_reset got a=%h b=%h exp 0", cnt_a, cnt_b);
        end
        n_rst = 1'b1;
        cycle();
        checks++;
        if (cnt_a[3:0] !== 4'd1) begin
            errors++;
            $display("FAIL post_reset got %0d exp 1", cnt_a[3:0]);
        end
    endtask

    // Random mix: direction flips, lowered terminals, zero terminal, loads, clears, resets.
    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            ce = 2'($urandom);
            if ($urandom_range(0, 7) == 0) cd = 2'($urandom);
            clr = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
            ld  = {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)};
            lv  = 8'($urandom);
            if ($urandom_range(0, 11) == 0) rv = 8'($urandom);
            if ($urandom_range(0, 30) == 0) rv = 8'h00;
            n_rst = ($urandom_range(0, 63) != 0);
            cycle();
        end
        n_rst = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                m_cnt[i][j]   = 4'd0;
                m_flag[i][j]  = 1'b0;
                m_pulse[i][j] = 1'b0;
            end
        end
        n_rst = 1'b0;
        ce = 2'b00; cd = 2'b00; clr = 2'b00; ld = 2'b00; lv = 8'h00; rv = 8'h00;
        test_reset();
        test_up();
        test_down();
        test_cascade();
        test_sticky();
        test_rv_zero();
        test_load_over();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
